iddmm_ctrl: RTL and testbench
=============================

IDDMM_CTRL -- requirements
Module: iddmm_ctrl

Interface
REQ-001 The block SHALL have parameter K, default 128, meaning bits per word.
REQ-002 The block SHALL have parameter N, default 32, meaning words per operand.
REQ-003 The block SHALL have parameter ADDR_W, default $clog2(N), meaning word address width.
REQ-004 The block SHALL have parameter ROW_GAP, default 24, meaning idle cycles inserted between outer rows so the datapath pipeline can retire the previous row.
REQ-005 The block SHALL have parameter TIMEOUT, default 1023, meaning the maximum cycles allowed in WAIT_DONE.
REQ-006 clk  in  1  the single clock; all logic is on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  one-cycle request to begin one Montgomery multiplication.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 i_cnt  out  ADDR_W  outer (y-word) index driven to the datapath.
REQ-011 j_cnt  out  ADDR_W+1  inner index 0..N driven to the datapath.
REQ-012 cnt_vld  out  1  i_cnt/j_cnt carry a valid issue this cycle.
REQ-013 rd_x_addr, rd_y_addr  out  ADDR_W each  operand RAM read addresses.
REQ-014 cal_done, cal_sign  in  1 each  datapath completion pulse and final-subtract select.
REQ-015 fifo_rd_en_a, fifo_rd_en_sub  out  1 each  pops of the raw-result and subtracted-result FIFOs (1-cycle read latency).
REQ-016 fifo_rd_data_a, fifo_rd_data_sub  in  K each  FIFO read data.
REQ-017 res_valid  out  1, res_ready  in  1, res_data  out  K  result word stream, least significant word first.
REQ-018 done  out  1, err  out  1  completion pulse and sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, GAP, WAIT_DONE, DRAIN.
REQ-020 In IDLE, start=1 SHALL move the FSM to ISSUE with i=0, j=0 and clear err; start in any other state SHALL be ignored.
REQ-021 In ISSUE, the block SHALL drive cnt_vld=1 and the current i/j, then increment j each cycle through 0..N.
REQ-022 At j=N with i<N-1, the block SHALL go to GAP, set j=0 and increment i.
REQ-023 At j=N with i=N-1, the block SHALL go to WAIT_DONE.
REQ-024 In GAP, the block SHALL drive cnt_vld=0 and hold i_cnt/j_cnt at the last issued value for exactly ROW_GAP cycles, then return to ISSUE.
REQ-025 With ROW_GAP=0, the block SHALL go directly from j=N to the next row with no gap.
REQ-026 The total issue span SHALL be N*(N+1) valid cycles plus (N-1)*ROW_GAP gap cycles.
REQ-027 rd_x_addr SHALL equal j when j<N, else 0; rd_y_addr SHALL equal i; both SHALL be combinational from the counters.
REQ-028 In WAIT_DONE, cal_done=1 SHALL latch cal_sign into sel and move the FSM to DRAIN.
REQ-029 If TIMEOUT cycles elapse in WAIT_DONE without cal_done, the block SHALL set err=1, pulse done and go to IDLE.
REQ-030 In DRAIN, for each of N words, the block SHALL assert fifo_rd_en_a and fifo_rd_en_sub together for one cycle.
REQ-031 On the next cycle, the block SHALL register fifo_rd_data_sub if sel=1, else fifo_rd_data_a, into res_data and set res_valid=1.
REQ-032 res_valid and res_data SHALL hold stable until res_ready=1.
REQ-033 The next pop SHALL issue only after the handshake completes.
REQ-034 Both FIFOs SHALL be popped exactly N times per operation so that both end empty.
REQ-035 Acceptance of word N-1 SHALL pulse done for 1 cycle, with busy falling in the same cycle, and return the FSM to IDLE.
REQ-036 A cal_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-037 rst_n=0 SHALL immediately force state IDLE, i=j=0, gap/timeout/word counters 0, and sel=0.
REQ-038 rst_n=0 SHALL immediately force all outputs to 0, including busy, cnt_vld, fifo_rd_en_*, res_valid, res_data, done and err.
REQ-039 Reset asserted mid-operation SHALL abandon the operation, with no done pulse.

Verification
REQ-040 N=4, ROW_GAP=2, start pulse: cnt_vld high for 4 runs of 5 cycles (j=0..4) separated by 2-cycle gaps; i_cnt=0,1,2,3; 26 cycles total before WAIT_DONE.
REQ-041 cal_done with cal_sign=1, FIFO sub words 0x11,0x22,0x33,0x44, res_ready=1: res_data sequence 0x11..0x44; 4 pops on each FIFO; one done pulse.
REQ-042 Same as REQ-041 with cal_sign=0 and A FIFO words 0xA0..0xA3: res_data 0xA0..0xA3.
REQ-043 res_ready held 0 for 5 cycles on word 1: res_data stable, no further pops until acceptance.
REQ-044 TIMEOUT=15, cal_done never asserted: err=1 and done pulse 15 cycles after entering WAIT_DONE; FSM in IDLE.
REQ-045 rst_n dropped in DRAIN after 2 words, plus start during ISSUE: all outputs 0 immediately; the mid-ISSUE start is ignored; a fresh start after reset runs normally.

Source files
------------

// File: rtl/iddmm_ctrl.sv
// Sequencer for an iterative Montgomery multiplier: issues (i,j) word indices,
// waits for the datapath, then streams the selected result FIFO out word by word.
module iddmm_ctrl #(
   parameter int K       = 128,
   parameter int N       = 32,
   parameter int ADDR_W  = $clog2(N),
   parameter int ROW_GAP = 24,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic [ADDR_W-1:0] i_cnt,
   output logic [ADDR_W:0]   j_cnt,
   output logic              cnt_vld,
   output logic [ADDR_W-1:0] rd_x_addr,
   output logic [ADDR_W-1:0] rd_y_addr,
   input  logic              cal_done,
   input  logic              cal_sign,
   output logic              fifo_rd_en_a,
   output logic              fifo_rd_en_sub,
   input  logic [K-1:0]      fifo_rd_data_a,
   input  logic [K-1:0]      fifo_rd_data_sub,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [K-1:0]      res_data,
   output logic              done,
   output logic              err
);

   localparam int GAP_W    = $clog2(ROW_GAP + 2);
   localparam int TO_W     = $clog2(TIMEOUT + 2);
   localparam int GAP_LAST = (ROW_GAP > 0) ? ROW_GAP - 1 : 0;
   localparam int TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   localparam logic [ADDR_W:0]   J_LAST = (ADDR_W+1)'(N);
   localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(N - 1);
   localparam logic [ADDR_W:0]   W_LAST = (ADDR_W+1)'(N - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      GAP       = 3'd2,
      WAIT_DONE = 3'd3,
      DRAIN     = 3'd4
   } state_t;

   state_t              state_r, state_n;
   logic [ADDR_W-1:0]   i_r, i_n;
   logic [ADDR_W:0]     j_r, j_n;
   logic [GAP_W-1:0]    g_r, g_n;
   logic [TO_W-1:0]     t_r, t_n;
   logic [ADDR_W:0]     w_r, w_n;
   logic                sel_r, sel_n;
   logic                err_r, err_n;
   logic                done_r, done_n;
   logic                busy_r, busy_n;
   logic                vld_r, vld_n;
   logic                rd_en_r, rd_en_n;
   logic                pend_r, pend_n;
   logic                res_valid_r, res_valid_n;
   logic [K-1:0]        res_data_r, res_data_n;

   // Next-state and next-output logic for the whole controller
   always_comb begin
      state_n     = state_r;
      i_n         = i_r;
      j_n         = j_r;
      g_n         = g_r;
      t_n         = t_r;
      w_n         = w_r;
      sel_n       = sel_r;
      err_n       = err_r;
      done_n      = 1'b0;
      rd_en_n     = 1'b0;
      pend_n      = rd_en_r;
      res_valid_n = res_valid_r;
      res_data_n  = res_data_r;

      case (state_r)
         IDLE: begin
            if (start) begin
               state_n = ISSUE;
               i_n     = {ADDR_W{1'b0}};
               j_n     = {(ADDR_W+1){1'b0}};
               err_n   = 1'b0;
            end else begin
               state_n = IDLE;
            end
         end
         ISSUE: begin
            if (j_r == J_LAST) begin
               if (i_r == I_LAST) begin
                  state_n = WAIT_DONE;
                  t_n     = {TO_W{1'b0}};
               end else if (ROW_GAP == 0) begin
                  i_n = i_r + ADDR_W'(1);
                  j_n = {(ADDR_W+1){1'b0}};
               end else begin
                  // counters hold the last issued pair through the gap
                  state_n = GAP;
                  g_n     = {GAP_W{1'b0}};
               end
            end else begin
               j_n = j_r + (ADDR_W+1)'(1);
            end
         end
         GAP: begin
            if (g_r == GAP_W'(GAP_LAST)) begin
               state_n = ISSUE;
               i_n     = i_r + ADDR_W'(1);
               j_n     = {(ADDR_W+1){1'b0}};
            end else begin
               g_n = g_r + GAP_W'(1);
            end
         end
         WAIT_DONE: begin
            if (cal_done) begin
               state_n = DRAIN;
               sel_n   = cal_sign;
               w_n     = {(ADDR_W+1){1'b0}};
            end else if (t_r == TO_W'(TO_LAST)) begin
               state_n = IDLE;
               err_n   = 1'b1;
               done_n  = 1'b1;
            end else begin
               t_n = t_r + TO_W'(1);
            end
         end
         DRAIN: begin
            // one word in flight at a time: pop, capture, then wait for accept
            if (res_valid_r && res_ready) begin
               res_valid_n = 1'b0;
               if (w_r == W_LAST) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  w_n = w_r + (ADDR_W+1)'(1);
               end
            end else if (pend_r) begin
               res_valid_n = 1'b1;
               res_data_n  = sel_r ? fifo_rd_data_sub : fifo_rd_data_a;
            end else if (!rd_en_r && !res_valid_r) begin
               rd_en_n = 1'b1;
            end else begin
               rd_en_n = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
      vld_n  = (state_n == ISSUE);
   end

   // State and registered-output update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         i_r         <= {ADDR_W{1'b0}};
         j_r         <= {(ADDR_W+1){1'b0}};
         g_r         <= {GAP_W{1'b0}};
         t_r         <= {TO_W{1'b0}};
         w_r         <= {(ADDR_W+1){1'b0}};
         sel_r       <= 1'b0;
         err_r       <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
         vld_r       <= 1'b0;
         rd_en_r     <= 1'b0;
         pend_r      <= 1'b0;
         res_valid_r <= 1'b0;
         res_data_r  <= {K{1'b0}};
      end else begin
         state_r     <= state_n;
         i_r         <= i_n;
         j_r         <= j_n;
         g_r         <= g_n;
         t_r         <= t_n;
         w_r         <= w_n;
         sel_r       <= sel_n;
         err_r       <= err_n;
         done_r      <= done_n;
         busy_r      <= busy_n;
         vld_r       <= vld_n;
         rd_en_r     <= rd_en_n;
         pend_r      <= pend_n;
         res_valid_r <= res_valid_n;
         res_data_r  <= res_data_n;
      end
   end

   assign busy           = busy_r;
   assign i_cnt          = i_r;
   assign j_cnt          = j_r;
   assign cnt_vld        = vld_r;
   assign rd_x_addr      = (j_r < J_LAST) ? j_r[ADDR_W-1:0] : {ADDR_W{1'b0}};
   assign rd_y_addr      = i_r;
   assign fifo_rd_en_a   = rd_en_r;
   assign fifo_rd_en_sub = rd_en_r;
   assign res_valid      = res_valid_r;
   assign res_data       = res_data_r;
   assign done           = done_r;
   assign err            = err_r;

endmodule

// File: tb/tb_iddmm_ctrl.sv
// Scoreboard bench for iddmm_ctrl: FIFO models, issue-order model and a
// negedge monitor that checks every issue, result word and done pulse.
module tb_iddmm_ctrl;
   localparam int K  = 32;
   localparam int N  = 4;
   localparam int AW = 2;
   localparam int RG = 2;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst_n, start, cal_done, cal_sign, res_ready;
   logic [K-1:0]  fifo_rd_data_a, fifo_rd_data_sub;
   logic          busy, cnt_vld, fifo_rd_en_a, fifo_rd_en_sub, res_valid, done, err;
   logic [AW-1:0] i_cnt, rd_x_addr, rd_y_addr;
   logic [AW:0]   j_cnt;
   logic [K-1:0]  res_data;

   iddmm_ctrl #(.K(K), .N(N), .ADDR_W(AW), .ROW_GAP(RG), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
      .i_cnt(i_cnt), .j_cnt(j_cnt), .cnt_vld(cnt_vld),
      .rd_x_addr(rd_x_addr), .rd_y_addr(rd_y_addr),
      .cal_done(cal_done), .cal_sign(cal_sign),
      .fifo_rd_en_a(fifo_rd_en_a), .fifo_rd_en_sub(fifo_rd_en_sub),
      .fifo_rd_data_a(fifo_rd_data_a), .fifo_rd_data_sub(fifo_rd_data_sub),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0;
   logic [K-1:0] qa[$], qs[$], exp_q[$];
   int exp_i[$], exp_j[$];
   int pops_a, pops_s, acc_cnt, done_cnt = 0, done_cyc, first_vld, last_vld, vld_cnt;
   bit in_span;
   bit prev_stall = 1'b0;
   logic [K-1:0] prev_data;
   int rdy_mode = 0, stall_left = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic nwait;
      @(negedge clk);
      #1;
   endtask

   always @(posedge clk) cyc++;

   // FIFO models with one-cycle read latency
   always @(posedge clk) begin
      if (rst_n) begin
         if (fifo_rd_en_a) begin
            pops_a++;
            fifo_rd_data_a <= (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_0BAD;
         end
         if (fifo_rd_en_sub) begin
            pops_s++;
            fifo_rd_data_sub <= (qs.size() > 0) ? qs.pop_front() : 32'hDEAD_5BAD;
         end
      end
   end

   // Monitor: compares DUT activity against the queued expectations
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (cnt_vld) begin
            int ei, ej;
            if (!in_span) begin
               in_span   = 1'b1;
               first_vld = cyc;
            end
            last_vld = cyc;
            vld_cnt++;
            if (exp_i.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL issue_extra: cnt_vld with i=%0d j=%0d and nothing expected", i_cnt, j_cnt);
            end else begin
               ei = exp_i.pop_front();
               ej = exp_j.pop_front();
               check("i_cnt", i_cnt, ei);
               check("j_cnt", j_cnt, ej);
               check("rd_x_addr", rd_x_addr, (ej < N) ? ej : 0);
               check("rd_y_addr", rd_y_addr, ei);
            end
         end
         if (prev_stall) check("hold_stable", {res_valid, res_data}, {1'b1, prev_data});
         if (fifo_rd_en_a || fifo_rd_en_sub) begin
            check("rd_en_pair", fifo_rd_en_a, fifo_rd_en_sub);
            check("pop_while_valid", res_valid, 1'b0);
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL res_extra: got %0h with nothing expected", res_data);
            end else begin
               check("res_data", res_data, exp_q.pop_front());
            end
            acc_cnt++;
         end
         prev_stall = res_valid && !res_ready;
         prev_data  = res_data;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_low_at_done", busy, 1'b0);
         end
      end
   end

   // res_ready driver: 0 always ready, 1 random, 2 stall word 1 for 5 cycles
   initial begin
      res_ready = 1'b0;
      forever begin
         tick();
         case (rdy_mode)
            1: res_ready = 1'($urandom_range(0, 1));
            2: begin
               if (res_valid && acc_cnt == 1 && stall_left > 0) begin
                  res_ready = 1'b0;
                  stall_left--;
               end else begin
                  res_ready = 1'b1;
               end
            end
            default: res_ready = 1'b1;
         endcase
      end
   end

   task automatic check_all_zero(input string name);
      check({name, "_ctl"}, {busy, cnt_vld, i_cnt, j_cnt, rd_x_addr, rd_y_addr,
                              fifo_rd_en_a, fifo_rd_en_sub, res_valid, done, err}, 0);
      check({name, "_data"}, res_data, 0);
   endtask

   // Loads the model for one operation and starts it, with a spurious
   // cal_done and a second start injected mid-issue.
   task automatic launch(input bit sign, input int pat, input bit load);
      logic [K-1:0] a, s;
      acc_cnt = 0; pops_a = 0; pops_s = 0; in_span = 1'b0; vld_cnt = 0;
      if (load) begin
         for (int k = 0; k < N; k++) begin
            a = (pat == 1) ? K'(32'hA0 + k)         : K'($urandom);
            s = (pat == 1) ? K'(32'h11 * (k + 1))   : K'($urandom);
            qa.push_back(a);
            qs.push_back(s);
            exp_q.push_back(sign ? s : a);
         end
      end
      for (int i = 0; i < N; i++)
         for (int j = 0; j <= N; j++) begin
            exp_i.push_back(i);
            exp_j.push_back(j);
         end
      start = 1'b1;
      tick();
      start = 1'b0;
      nwait();
      check("busy_after_start", busy, 1'b1);
      check("err_cleared", err, 1'b0);
      repeat (3) tick();
      cal_done = 1'b1; cal_sign = ~sign; start = 1'b1;
      tick();
      cal_done = 1'b0; start = 1'b0;
      for (int c = 0; c < 300 && exp_i.size() != 0; c++) nwait();
      check("issue_complete", exp_i.size(), 0);
      check("issue_span", last_vld - first_vld + 1, N * (N + 1) + (N - 1) * RG);
      check("issue_valid_cycles", vld_cnt, N * (N + 1));
   endtask

   task automatic run_op(input bit sign, input int pat, input int mode);
      int base;
      rdy_mode = mode; stall_left = 5;
      base = done_cnt;
      launch(sign, pat, 1'b1);
      tick();
      repeat ($urandom_range(0, 6)) tick();
      cal_done = 1'b1; cal_sign = sign;
      tick();
      cal_done = 1'b0;
      for (int c = 0; c < 500 && done_cnt == base; c++) nwait();
      check("done_pulses", done_cnt - base, 1);
      check("results_left", exp_q.size(), 0);
      check("pops_a", pops_a, N);
      check("pops_sub", pops_s, N);
      check("fifos_empty", qa.size() + qs.size(), 0);
      check("err_ok", err, 1'b0);
      nwait();
      check("done_one_cycle", done, 1'b0);
   endtask

   task automatic run_timeout;
      int base;
      base = done_cnt;
      launch(1'b0, 0, 1'b0);
      for (int c = 0; c < 100 && done_cnt == base; c++) nwait();
      check("timeout_done", done_cnt - base, 1);
      check("timeout_latency", done_cyc - last_vld, TO + 1);
      check("timeout_err", err, 1'b1);
      check("timeout_idle", busy, 1'b0);
      check("timeout_no_pops", pops_a + pops_s, 0);
      repeat (3) tick();
      check("err_sticky", err, 1'b1);
   endtask

   task automatic run_reset;
      int base;
      rdy_mode = 0;
      base = done_cnt;
      launch(1'b1, 0, 1'b1);
      tick();
      cal_done = 1'b1; cal_sign = 1'b1;
      tick();
      cal_done = 1'b0;
      for (int c = 0; c < 100 && acc_cnt < 2; c++) nwait();
      check("two_words_before_reset", acc_cnt, 2);
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      qa.delete(); qs.delete(); exp_q.delete(); exp_i.delete(); exp_j.delete();
      repeat (2) tick();
      check_all_zero("held_reset");
      rst_n = 1'b1;
      repeat (2) tick();
      check("no_done_on_reset", done_cnt - base, 0);
      check("idle_after_reset", busy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cal_done = 1'b0; cal_sign = 1'b0;
      fifo_rd_data_a = '0; fifo_rd_data_sub = '0;
      #12;
      check_all_zero("reset");
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check_all_zero("idle");
      run_op(1'b1, 1, 0);
      run_op(1'b0, 1, 0);
      run_op(1'b1, 0, 2);
      run_timeout();
      run_op(1'b0, 0, 0);
      run_reset();
      for (int r = 0; r < 4; r++) run_op(1'($urandom_range(0, 1)), 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
